isolator_deserializer: RTL and testbench
========================================

// Module: isolator_deserializer
// PURPOSE
//  Receive end of the isolator-PCB serial link. The far end is a 74165-style
//  parallel-load shift register driving MSB first. This block recovers each
//  WIDTH-bit word in the system clock domain and presents it on a valid/ready
//  port to the control logic. The ser_* inputs are asynchronous to clk.
// PARAMETERS
//  WIDTH        8  bits per frame, MSB first
//  SYNC_STAGES  2  flip-flop synchronizer depth on each ser_* input, >=2
// PORTS
//  clk            in   1      system clock; all logic on rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  ser_clk        in   1      link shift clock; transmitter shifts on rising edge
//  ser_data       in   1      link data; holds bit[WIDTH-1] right after load
//  ser_latch      in   1      link load strobe, active-low; low = transmitter loading
//  par_data       out  WIDTH  received word; held stable while par_valid=1
//  par_valid      out  1      word available
//  par_ready      in   1      consumer accepts when par_valid & par_ready
//  overrun        out  1      sticky: a completed word was dropped because output was full
//  frame_err      out  1      sticky: ser_latch went low mid-frame and the partial word was dropped
//  clear_flags    in   1      synchronous; clears overrun and frame_err
// BEHAVIOUR
//  Reset values
//  - par_data=0, par_valid=0, overrun=0, frame_err=0, state=IDLE, count=0.
//  - Synchronizers reset to ser_clk=0, ser_latch=1 (inactive), ser_data=0.
//  Sampling
//  - ser_clk, ser_data and ser_latch each pass through SYNC_STAGES flops (sclk_s, sdat_s, slat_s).
//  - Rise = sclk_s=1 and its previous-cycle value=0.
//  - Sampled bit = sdat_s delayed one more clk, i.e. the value present before the edge.
//  - Link requirement: ser_clk high and low phases each >= SYNC_STAGES+2 clk periods.
//  - Link requirement: ser_data settles within 1 clk after a ser_clk rise.
//  State machine
//  - IDLE: rises ignored. slat_s=0 -> LOAD.
//  - LOAD: rises ignored (load dominates). count<=0. slat_s=1 -> SHIFT.
//  - SHIFT: each rise does shreg<={shreg[WIDTH-2:0],bit} and count<=count+1.
//  - SHIFT: on the rise where count==WIDTH-1, the word is complete -> IDLE.
//  - SHIFT: slat_s=0 -> LOAD. If count!=0, set frame_err and discard shreg.
//  - slat_s=0 in any state -> LOAD. This takes priority over a simultaneous rise.
//  - count is $clog2(WIDTH)+1 bits wide and never exceeds WIDTH-1.
//  Output handshake
//  - A complete word is loaded into par_data the cycle after the final rise is
//    detected. par_valid=1 that same cycle.
//  - Load is allowed when par_valid=0, or when par_valid&par_ready in that cycle
//    (same-cycle accept and reload: par_valid stays 1 and par_data takes the new word).
//  - If a word completes while par_valid=1 and par_ready=0, the new word is dropped,
//    overrun<=1, and par_data is unchanged.
//  - par_valid falls the cycle after accept, unless a reload happens in that cycle.
//  Flags
//  - overrun and frame_err are sticky. clear_flags clears them.
//  - A set event in the same cycle as clear_flags wins: the flag stays 1.
//  Latency
//  - Physical final ser_clk rise to par_valid: SYNC_STAGES+2 clk cycles.
//  Reset mid-operation
//  - Aborts the frame immediately. No frame_err is recorded.
//  - The first frame after reset requires a fresh ser_latch low pulse.
// TESTING
//  - Send one frame 0xA5 (latch pulse, 8 ser_clk), par_ready=1 -> one par_valid
//    pulse with par_data=0xA5 at SYNC_STAGES+2 clk after edge 8; flags remain 0.
//  - par_ready=0, send 0x12 then 0x34 -> par_data stays 0x12, overrun=1; raise
//    par_ready -> 0x12 accepted once, par_valid=0 after; clear_flags -> overrun=0.
//  - Latch low after 3 bits of a frame, then full frame 0x3C -> frame_err=1, no
//    word for the partial frame, next word 0x3C.
//  - 5 ser_clk pulses with no latch after reset, then frame 0xF0 -> no par_valid
//    for the stray edges; par_data=0xF0.
//  - Back-to-back frames 0x01,0x80 with par_ready pulsed in the cycle the second word
//    completes -> par_valid held high, par_data 0x01 then 0x80, overrun=0.
//  - Assert reset after bit 4 of a frame -> all outputs zero; next frame 0x5A
//    received correctly, frame_err=0.

Source files
------------

// File: rtl/isolator_deserializer.sv
// Receive end of the isolator serial link: synchronizes a 74165-style MSB-first
// stream into clk and presents each recovered word on a valid/ready port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a load strobe; link clock edges are ignored
// LOAD  | transmitter is parallel-loading; bit counter held at zero
// SHIFT | capturing one bit per link clock rise until the word is full

module isolator_deserializer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_clk,
    input  logic             ser_data,
    input  logic             ser_latch,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clear_flags
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdat_sync;
    logic [SYNC_STAGES-1:0] slat_sync;
    logic                   sclk_s;
    logic                   sdat_s;
    logic                   slat_s;
    logic                   sclk_prev;
    logic                   sdat_d;
    logic                   rise;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic [WIDTH-1:0]       shreg;
    logic                   shift_en;
    logic                   word_last;
    logic                   word_done;
    logic                   frame_abort;
    logic                   accept;
    logic                   can_load;

    // latch synchronizer idles high so reset never looks like a load strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            sdat_sync <= '0;
            slat_sync <= '1;
            sclk_prev <= 1'b0;
            sdat_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ser_clk};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], ser_data};
            slat_sync <= {slat_sync[SYNC_STAGES-2:0], ser_latch};
            sclk_prev <= sclk_s;
            sdat_d    <= sdat_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdat_s = sdat_sync[SYNC_STAGES-1];
    assign slat_s = slat_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            shreg     <= '0;
            word_done <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            word_done <= word_last;
            if (shift_en) begin
                shreg <= {shreg[WIDTH-2:0], sdat_d};
            end
        end
    end

    // load strobe wins over any edge arriving in the same cycle
    always_comb begin
        state_next  = state;
        count_next  = count;
        shift_en    = 1'b0;
        word_last   = 1'b0;
        frame_abort = 1'b0;
        if (!slat_s) begin
            state_next = LOAD;
            count_next = '0;
            if ((state == SHIFT) && (count != '0)) begin
                frame_abort = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                LOAD: begin
                    state_next = SHIFT;
                    count_next = '0;
                end
                SHIFT: begin
                    if (rise) begin
                        shift_en = 1'b1;
                        if (count == LAST_BIT) begin
                            word_last  = 1'b1;
                            count_next = '0;
                            state_next = IDLE;
                        end else begin
                            count_next = count + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign accept   = par_valid & par_ready;
    assign can_load = ~par_valid | par_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_data  <= '0;
            par_valid <= 1'b0;
        end else if (word_done && can_load) begin
            par_data  <= shreg;
            par_valid <= 1'b1;
        end else if (accept) begin
            par_valid <= 1'b0;
        end
    end

    // a set event in the same cycle as clear_flags keeps the flag high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (word_done && !can_load) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (frame_abort) begin
                frame_err <= 1'b1;
            end else if (clear_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isolator_deserializer.sv
// Directed bench for isolator_deserializer: drives a 74165-style link and
// checks recovered words, latency, handshake and sticky flags.

module tb_isolator_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_clk;
    logic       ser_data;
    logic       ser_latch;
    logic [7:0] par_data;
    logic       par_valid;
    logic       par_ready;
    logic       overrun;
    logic       frame_err;
    logic       clear_flags;

    int         n_chk = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_rise = 0;
    int         vld_rise_cyc = 0;
    int         vld_fall_cyc = 0;
    int         vld_rises = 0;
    int         vld_falls = 0;
    logic       pv_prev = 1'b0;
    logic [7:0] got_q[$];
    int         base_n;
    int         base_f;

    isolator_deserializer #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch),
        .par_data   (par_data),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // inputs change 1 unit after posedge, so negedge sees settled values
    always @(negedge clk) begin
        if (par_valid && !pv_prev) begin
            vld_rises++;
            vld_rise_cyc = cyc;
        end
        if (!par_valid && pv_prev) begin
            vld_falls++;
            vld_fall_cyc = cyc;
        end
        if (par_valid && par_ready) got_q.push_back(par_data);
        pv_prev = par_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got time %0t want < 1000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ser_rise(input logic nd);
        wait_cyc(5);
        ser_clk   = 1'b1;
        ser_data  = nd;
        last_rise = cyc;
    endtask

    task automatic ser_fall();
        wait_cyc(5);
        ser_clk = 1'b0;
    endtask

    task automatic latch_pulse(input logic [7:0] w);
        ser_latch = 1'b0;
        ser_data  = w[7];
        wait_cyc(5);
        ser_latch = 1'b1;
    endtask

    task automatic shift_bits(input logic [7:0] w, input int n);
        logic [7:0] sh;
        sh = w;
        for (int k = 0; k < n; k++) begin
            sh = sh << 1;
            ser_rise(sh[7]);
            ser_fall();
        end
    endtask

    task automatic send_frame(input logic [7:0] w);
        latch_pulse(w);
        shift_bits(w, 8);
        wait_cyc(5);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(2);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        wait_cyc(1);
        clear_flags = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        reset       = 1'b1;
        ser_clk     = 1'b0;
        ser_data    = 1'b0;
        ser_latch   = 1'b1;
        par_ready   = 1'b0;
        clear_flags = 1'b0;
        wait_cyc(3);
        chk("rst_par_data", 32'(par_data), 32'h00);
        chk("rst_par_valid", 32'(par_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_cyc(3);

        // single frame, consumer always ready
        par_ready = 1'b1;
        base_n = got_q.size();
        send_frame(8'hA5);
        chk("a5_latency", 32'(vld_rise_cyc - last_rise), 32'd4);
        chk("a5_pulse_width", 32'(vld_fall_cyc - vld_rise_cyc), 32'd1);
        chk("a5_count", 32'(got_q.size() - base_n), 32'd1);
        chk("a5_word", 32'(got_q[$]), 32'hA5);
        chk("a5_overrun", 32'(overrun), 32'h0);
        chk("a5_frame_err", 32'(frame_err), 32'h0);

        // overrun: second word dropped while first is still held
        par_ready = 1'b0;
        base_n = got_q.size();
        send_frame(8'h12);
        send_frame(8'h34);
        chk("ovr_par_data", 32'(par_data), 32'h12);
        chk("ovr_par_valid", 32'(par_valid), 32'h1);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_frame_err", 32'(frame_err), 32'h0);
        par_ready = 1'b1;
        wait_cyc(4);
        chk("ovr_accept_count", 32'(got_q.size() - base_n), 32'd1);
        chk("ovr_accept_word", 32'(got_q[$]), 32'h12);
        chk("ovr_valid_after", 32'(par_valid), 32'h0);
        pulse_clear();
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // partial frame aborted by a new load strobe
        base_n = got_q.size();
        latch_pulse(8'hFF);
        shift_bits(8'hFF, 3);
        send_frame(8'h3C);
        chk("ferr_flag", 32'(frame_err), 32'h1);
        chk("ferr_count", 32'(got_q.size() - base_n), 32'd1);
        chk("ferr_word", 32'(got_q[$]), 32'h3C);
        pulse_clear();
        chk("ferr_cleared", 32'(frame_err), 32'h0);

        // stray link clocks after reset without a load strobe
        pulse_reset();
        base_n = vld_rises;
        shift_bits(8'hFF, 5);
        wait_cyc(8);
        chk("stray_no_valid", 32'(vld_rises - base_n), 32'd0);
        chk("stray_par_valid", 32'(par_valid), 32'h0);
        send_frame(8'hF0);
        chk("stray_next_word", 32'(got_q[$]), 32'hF0);
        chk("stray_par_data", 32'(par_data), 32'hF0);

        // back-to-back words with same-cycle accept and reload
        par_ready = 1'b0;
        send_frame(8'h01);
        chk("b2b_first_valid", 32'(par_valid), 32'h1);
        base_f = vld_falls;
        base_n = got_q.size();
        latch_pulse(8'h80);
        shift_bits(8'h80, 7);
        ser_rise(1'b0);
        wait_cyc(3);
        par_ready = 1'b1;
        wait_cyc(1);
        par_ready = 1'b0;
        chk("b2b_valid_held", 32'(par_valid), 32'h1);
        chk("b2b_reload", 32'(par_data), 32'h80);
        chk("b2b_first_taken", 32'(got_q[$]), 32'h01);
        chk("b2b_one_taken", 32'(got_q.size() - base_n), 32'd1);
        ser_fall();
        wait_cyc(5);
        chk("b2b_no_drop", 32'(vld_falls - base_f), 32'd0);
        chk("b2b_overrun", 32'(overrun), 32'h0);
        par_ready = 1'b1;
        wait_cyc(3);
        chk("b2b_second_word", 32'(got_q[$]), 32'h80);
        chk("b2b_drained", 32'(par_valid), 32'h0);

        // reset in the middle of a frame
        latch_pulse(8'hC3);
        shift_bits(8'hC3, 4);
        reset = 1'b1;
        wait_cyc(2);
        chk("mrst_par_data", 32'(par_data), 32'h00);
        chk("mrst_par_valid", 32'(par_valid), 32'h0);
        chk("mrst_overrun", 32'(overrun), 32'h0);
        chk("mrst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_cyc(3);
        base_n = got_q.size();
        send_frame(8'h5A);
        chk("mrst_count", 32'(got_q.size() - base_n), 32'd1);
        chk("mrst_word", 32'(got_q[$]), 32'h5A);
        chk("mrst_no_ferr", 32'(frame_err), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
